// File: rtl/xadac_pkg.sv
// Shared types and default sizing for the xadac execute stage.
// The dispatcher's order FIFO depth and per-unit in-flight bound default from here.
package xadac_pkg;

    localparam int NoUnitsDefault = 5;
    localparam int DispatchDepth  = 8;
    localparam int DispatchMaxOut = 4;

    typedef logic [31:0] InstrT;
    typedef logic [$clog2(NoUnitsDefault)-1:0] UnitIdxT;

    // Index width for a unit count, kept at least one bit wide.
    function automatic int unit_idx_width(input int no_units);
        return (no_units > 1) ? $clog2(no_units) : 1;
    endfunction

endpackage

// File: rtl/xadac_order_fifo.sv
// Issue-order FIFO: remembers which unit each in-flight op went to.
// Head is read combinationally so the response mux follows the oldest op.
module xadac_order_fifo #(
    parameter int Depth = 8,
    parameter int Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_reg;
    logic [PtrW-1:0]  rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            end
        end
    end

    // Contents carry no reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AddrW-1:0]] <= push_data;
        end
    end

    assign full  = (wr_ptr_reg[AddrW-1:0] == rd_ptr_reg[AddrW-1:0]) &&
                   (wr_ptr_reg[AddrW] != rd_ptr_reg[AddrW]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign head  = mem[rd_ptr_reg[AddrW-1:0]];

endmodule

// File: rtl/xadac_exe_dispatch.sv
// Execute-stage dispatcher: decodes each request to a unit by mask/match,
// bounds per-unit in-flight ops and returns responses strictly in issue order.
module xadac_exe_dispatch
    import xadac_pkg::*;
#(
    parameter int                  NoUnits  = 5,
    parameter int                  Depth    = DispatchDepth,
    parameter int                  MaxOut   = DispatchMaxOut,
    parameter int                  ReqWidth = 64,
    parameter int                  RspWidth = 64,
    parameter InstrT [NoUnits-1:0] Mask     = '0,
    parameter InstrT [NoUnits-1:0] Match    = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 req_instr,
    input  logic [ReqWidth-1:0]         req_data,
    output logic [NoUnits-1:0]          unit_req_valid,
    input  logic [NoUnits-1:0]          unit_req_ready,
    output logic [31:0]                 unit_req_instr,
    output logic [ReqWidth-1:0]         unit_req_data,
    input  logic [NoUnits-1:0]          unit_rsp_valid,
    output logic [NoUnits-1:0]          unit_rsp_ready,
    input  logic [NoUnits*RspWidth-1:0] unit_rsp_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [RspWidth-1:0]         rsp_data,
    output logic [$clog2(NoUnits)-1:0]  rsp_unit
);

    localparam int IdxW = unit_idx_width(NoUnits);
    localparam int CntW = $clog2(MaxOut + 1);

    logic [IdxW-1:0]    sel;
    logic [IdxW-1:0]    head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NoUnits-1:0] at_max;
    logic               issue_ok;
    logic               push;
    logic               pop;

    // Lowest matching unit wins; the last unit is the catch-all sink.
    always_comb begin
        sel = IdxW'(NoUnits - 1);
        for (int i = NoUnits - 2; i >= 0; i--) begin
            if ((req_instr & Mask[i]) == Match[i]) begin
                sel = IdxW'(i);
            end
        end
    end

    assign issue_ok       = !rst && req_valid && !fifo_full && !at_max[sel];
    assign unit_req_valid = issue_ok ? (NoUnits'(1) << sel) : '0;
    assign req_ready      = issue_ok && unit_req_ready[sel];
    assign unit_req_instr = req_instr;
    assign unit_req_data  = req_data;
    assign push           = req_valid && req_ready;

    // Only the unit owning the oldest op may hand back a response.
    assign rsp_valid      = !rst && !fifo_empty && unit_rsp_valid[head];
    assign rsp_data       = unit_rsp_data[head*RspWidth +: RspWidth];
    assign rsp_unit       = head;
    assign unit_rsp_ready = (!rst && rsp_ready && !fifo_empty) ? (NoUnits'(1) << head) : '0;
    assign pop            = rsp_valid && rsp_ready;

    xadac_order_fifo #(
        .Depth (Depth),
        .Width (IdxW)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sel),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NoUnits; gi++) begin : gen_cnt
            logic [CntW-1:0] out_cnt_reg;
            logic            inc;
            logic            dec;

            assign inc        = push && (sel == IdxW'(gi));
            assign dec        = pop && (head == IdxW'(gi));
            assign at_max[gi] = (out_cnt_reg == CntW'(MaxOut));

            // A same-cycle issue and retire on this unit cancel out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_cnt_reg <= '0;
                end else if (inc && !dec) begin
                    out_cnt_reg <= out_cnt_reg + CntW'(1);
                end else if (dec && !inc) begin
                    out_cnt_reg <= out_cnt_reg - CntW'(1);
                end
            end
        end
    endgenerate

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && fifo_empty));
            assert (!(push && fifo_full));
            assert ($onehot0(unit_req_valid));
            assert ($onehot0(unit_rsp_ready));
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (req_valid && !req_ready) |=> ($stable(req_instr) && $stable(req_data)));
`endif

endmodule
